reg_access_sequencer: RTL and testbench
=======================================

// Module: reg_access_sequencer
// PURPOSE
//   Upstream address/data source for the 32x32 register file. Generates W_Addr, W_Data,
//   Write_Reg and the two read addresses. Modes: automatic init sweep of all 32
//   registers, single manual write, and a timed read-scan for the display stage.
//   Outputs connect straight to the register file inputs. Replaces the combinational
//   data-selector/address-creator pair.
// PARAMETERS
//   ADDR_W    5   register address width (32 registers)
//   DATA_W    32  register data width
//   SCAN_DIV  4   Clk cycles per scan step in SCAN (>=1)
// PORTS
//   Clk        in   1       single clock, rising edge
//   Reset      in   1       asynchronous, active-low reset
//   Start      in   1       level input; rising edge starts the init sweep
//   Write_Req  in   1       level input; rising edge requests one manual write
//   Scan_En    in   1       1 = run read-scan when idle
//   Select     in   2       data pattern select
//   Addr       in   ADDR_W  manual write/read address
//   W_Addr     out  ADDR_W  register file write address
//   W_Data     out  DATA_W  register file write data
//   Write_Reg  out  1       register file write enable
//   R_Addr_A   out  ADDR_W  read port A address
//   R_Addr_B   out  ADDR_W  read port B address
//   Busy       out  1       high in INIT or MWR
//   Done       out  1       one-cycle pulse after the last init write
// BEHAVIOUR
//   Reset low: state=IDLE. All outputs 0: W_Addr, W_Data, Write_Reg, R_Addr_A/B, Busy,
//     Done. Edge-detect history regs cleared. Takes effect immediately, including mid-INIT.
//   All outputs are registered. Start/Write_Req edges are detected on registered history.
//     An edge sampled at edge n acts at edge n+1.
//   pattern(sel,a), a 5-bit:
//     00 -> {27'b0,a}
//     01 -> {4{3'b0,a}}
//     10 -> 32'h1<<a
//     11 -> ~(32'h1<<a)
//   IDLE:
//     Write_Reg=0. R_Addr_A=Addr, R_Addr_B=Addr+1 (mod 32). Registered, 1-cycle lag.
//     Start edge -> INIT. Takes priority over Write_Req edge in the same cycle.
//     Else Write_Req edge -> MWR.
//     Else Scan_En=1 -> SCAN.
//   INIT:
//     32 consecutive cycles with Write_Reg=1, W_Addr=0..31, W_Data=pattern(Select,W_Addr).
//     Select is sampled per cycle. Address 0 is written too; the register file discards it.
//     Write_Req and Scan_En are ignored, not queued. A Start edge restarts at W_Addr=0.
//     After W_Addr=31: Write_Reg=0, Done=1 for one cycle, -> IDLE.
//   MWR:
//     One cycle with Write_Reg=1, W_Addr=Addr, W_Data=pattern(Select,Addr). Then -> IDLE.
//   SCAN:
//     R_Addr_A advances +1 (wraps 31->0) every SCAN_DIV cycles.
//     R_Addr_B = R_Addr_A+1 (mod 32). Write_Reg=0. Divider starts at 0 on entry.
//     Scan_En=0 -> IDLE next cycle; addresses hold until IDLE reloads them.
//     Start edge -> INIT. Write_Req edge -> MWR. The scan position is lost.
//   Busy=1 exactly while state is INIT or MWR (registered with state).
// STRUCTURE
//   Shared include reg_seq_defs.vh: state encodings IDLE/INIT/MWR/SCAN (2-bit), pattern
//     select codes, REG_COUNT=32.
//   One sub-module: rise_detect (registered rising-edge detector, async active-low reset).
//     Instantiated once each for Start and Write_Req.
//   Main module: FSM, 5-bit sweep counter, scan divider, pattern mux.
// TESTING
//   Reset low mid-INIT (W_Addr=13) -> all outputs 0 same cycle; IDLE after release.
//   Select=10, Start edge -> 32 writes, W_Addr 0..31, W_Data 1<<addr, W_Data(31)=32'h8000_0000;
//     Done one cycle after; Busy high 32 cycles.
//   IDLE, Addr=5, Select=01, Write_Req edge -> single write W_Addr=5, W_Data=32'h0505_0505;
//     holding Write_Req high gives no repeat.
//   Start and Write_Req rising same cycle -> INIT only, no MWR afterwards.
//   Scan_En=1, SCAN_DIV=4 -> R_Addr_A 0,1,2.. every 4 cycles; R_Addr_A=31 gives R_Addr_B=0
//     and next R_Addr_A=0.
//   Write_Req edge during INIT -> ignored; exactly 32 writes, no trailing MWR.

Source files
------------

// File: rtl/reg_access_sequencer_pkg.sv
// Shared definitions for the register-file access sequencer: state encoding,
// data-pattern select codes, register count and the write-data pattern generator.
package reg_access_sequencer_pkg;

    localparam int unsigned SEQ_ADDR_W = 5;
    localparam int unsigned SEQ_DATA_W = 32;
    localparam int unsigned REG_COUNT  = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_MWR  = 2'd2,
        ST_SCAN = 2'd3
    } state_e;

    localparam logic [1:0] SEL_ADDR     = 2'b00;
    localparam logic [1:0] SEL_REPEAT   = 2'b01;
    localparam logic [1:0] SEL_ONE_HOT  = 2'b10;
    localparam logic [1:0] SEL_ONE_COLD = 2'b11;

    // Write-data pattern derived from the target address.
    function automatic logic [SEQ_DATA_W-1:0] pattern(input logic [1:0]            sel,
                                                      input logic [SEQ_ADDR_W-1:0] a);
        logic [SEQ_DATA_W-1:0] one_hot;
        logic [SEQ_DATA_W-1:0] result;
        one_hot = SEQ_DATA_W'(1) << a;
        case (sel)
            SEL_ADDR:     result = SEQ_DATA_W'(a);
            SEL_REPEAT:   result = {4{3'b000, a}};
            SEL_ONE_HOT:  result = one_hot;
            SEL_ONE_COLD: result = ~one_hot;
            default:      result = '0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/reg_access_sequencer_rise_detect.sv
// Registered rising-edge detector.
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous active-low reset (clears history and pulse)
//   level  in  level input to watch
//   rise   out one-cycle pulse, registered, the cycle after a 0->1 was sampled
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic rise
);

    logic hist_q, hist_d;
    logic rise_q, rise_d;

    // History holds the previous sample; pulse when the new sample is high and history low.
    always_comb begin
        hist_d = level;
        rise_d = level & ~hist_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            hist_q <= hist_d;
            rise_q <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/reg_access_sequencer.sv
// Address/data source for the 32x32 register file: init sweep of all registers,
// single manual write, and a timed read-address scan for the display stage.
//   Clk        in   clock, rising edge
//   Reset      in   asynchronous active-low reset
//   Start      in   level; rising edge starts (or restarts) the init sweep
//   Write_Req  in   level; rising edge requests one manual write
//   Scan_En    in   run the read scan while otherwise idle
//   Select     in   data pattern select
//   Addr       in   manual write address / idle read address
//   W_Addr     out  register file write address
//   W_Data     out  register file write data
//   Write_Reg  out  register file write enable
//   R_Addr_A   out  read port A address
//   R_Addr_B   out  read port B address (A+1 mod 32)
//   Busy       out  high while sweeping or doing a manual write
//   Done       out  one-cycle pulse after the last sweep write
module reg_access_sequencer
    import reg_access_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W   = SEQ_ADDR_W,
    parameter int unsigned DATA_W   = SEQ_DATA_W,
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Write_Req,
    input  logic              Scan_En,
    input  logic [1:0]        Select,
    input  logic [ADDR_W-1:0] Addr,
    output logic [ADDR_W-1:0] W_Addr,
    output logic [DATA_W-1:0] W_Data,
    output logic              Write_Reg,
    output logic [ADDR_W-1:0] R_Addr_A,
    output logic [ADDR_W-1:0] R_Addr_B,
    output logic              Busy,
    output logic              Done
);

    localparam int unsigned       DIV_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(REG_COUNT - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_TWO  = ADDR_W'(2);

    logic start_rise;
    logic wreq_rise;

    state_e            state_q,     state_d;
    logic [ADDR_W-1:0] w_addr_q,    w_addr_d;
    logic [DATA_W-1:0] w_data_q,    w_data_d;
    logic              write_reg_q, write_reg_d;
    logic [ADDR_W-1:0] r_addr_a_q,  r_addr_a_d;
    logic [ADDR_W-1:0] r_addr_b_q,  r_addr_b_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;
    logic [DIV_W-1:0]  div_q,       div_d;

    rise_detect u_start_rise (
        .clk   (Clk),
        .rst_n (Reset),
        .level (Start),
        .rise  (start_rise)
    );

    rise_detect u_wreq_rise (
        .clk   (Clk),
        .rst_n (Reset),
        .level (Write_Req),
        .rise  (wreq_rise)
    );

    // Next state and next registered outputs; every output is a flop loaded here.
    always_comb begin
        state_d     = state_q;
        w_addr_d    = w_addr_q;
        w_data_d    = w_data_q;
        write_reg_d = 1'b0;
        r_addr_a_d  = r_addr_a_q;
        r_addr_b_d  = r_addr_b_q;
        done_d      = 1'b0;
        div_d       = div_q;

        case (state_q)
            ST_IDLE: begin
                r_addr_a_d = Addr;
                r_addr_b_d = Addr + ADDR_ONE;
                div_d      = '0;
                if (start_rise) begin
                    state_d     = ST_INIT;
                    write_reg_d = 1'b1;
                    w_addr_d    = '0;
                    w_data_d    = DATA_W'(pattern(Select, SEQ_ADDR_W'(0)));
                end else if (wreq_rise) begin
                    state_d     = ST_MWR;
                    write_reg_d = 1'b1;
                    w_addr_d    = Addr;
                    w_data_d    = DATA_W'(pattern(Select, SEQ_ADDR_W'(Addr)));
                end else if (Scan_En) begin
                    state_d = ST_SCAN;
                end
            end

            // W_Addr doubles as the sweep counter; a new Start edge rewinds it.
            ST_INIT: begin
                if (start_rise) begin
                    write_reg_d = 1'b1;
                    w_addr_d    = '0;
                    w_data_d    = DATA_W'(pattern(Select, SEQ_ADDR_W'(0)));
                end else if (w_addr_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    write_reg_d = 1'b1;
                    w_addr_d    = w_addr_q + ADDR_ONE;
                    w_data_d    = DATA_W'(pattern(Select, SEQ_ADDR_W'(w_addr_q + ADDR_ONE)));
                end
            end

            ST_MWR: begin
                state_d = ST_IDLE;
            end

            // Addresses hold on exit; IDLE reloads them from Addr on its first cycle.
            ST_SCAN: begin
                if (start_rise) begin
                    state_d     = ST_INIT;
                    write_reg_d = 1'b1;
                    w_addr_d    = '0;
                    w_data_d    = DATA_W'(pattern(Select, SEQ_ADDR_W'(0)));
                end else if (wreq_rise) begin
                    state_d     = ST_MWR;
                    write_reg_d = 1'b1;
                    w_addr_d    = Addr;
                    w_data_d    = DATA_W'(pattern(Select, SEQ_ADDR_W'(Addr)));
                end else if (!Scan_En) begin
                    state_d = ST_IDLE;
                end else if (div_q == DIV_LAST) begin
                    div_d      = '0;
                    r_addr_a_d = r_addr_a_q + ADDR_ONE;
                    r_addr_b_d = r_addr_a_q + ADDR_TWO;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_INIT) || (state_d == ST_MWR);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= ST_IDLE;
            w_addr_q    <= '0;
            w_data_q    <= '0;
            write_reg_q <= 1'b0;
            r_addr_a_q  <= '0;
            r_addr_b_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            div_q       <= '0;
        end else begin
            state_q     <= state_d;
            w_addr_q    <= w_addr_d;
            w_data_q    <= w_data_d;
            write_reg_q <= write_reg_d;
            r_addr_a_q  <= r_addr_a_d;
            r_addr_b_q  <= r_addr_b_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            div_q       <= div_d;
        end
    end

    assign W_Addr    = w_addr_q;
    assign W_Data    = w_data_q;
    assign Write_Reg = write_reg_q;
    assign R_Addr_A  = r_addr_a_q;
    assign R_Addr_B  = r_addr_b_q;
    assign Busy      = busy_q;
    assign Done      = done_q;

endmodule

// File: tb/tb_reg_access_sequencer.sv
// Self-checking bench for reg_access_sequencer with a queue-based write monitor
// and an arithmetic reference for the data patterns and scan addresses.
module tb_reg_access_sequencer;

    localparam int unsigned AW  = 5;
    localparam int unsigned DW  = 32;
    localparam int unsigned DIV = 4;

    logic          clk;
    logic          Reset;
    logic          Start;
    logic          Write_Req;
    logic          Scan_En;
    logic [1:0]    Select;
    logic [AW-1:0] Addr;
    logic [AW-1:0] W_Addr;
    logic [DW-1:0] W_Data;
    logic          Write_Reg;
    logic [AW-1:0] R_Addr_A;
    logic [AW-1:0] R_Addr_B;
    logic          Busy;
    logic          Done;

    int n_checks;
    int n_pass;

    // Monitor state, refreshed by step().
    int            cyc;
    int            done_cnt;
    int            done_cyc;
    int            busy_cnt;
    int            first_wr_cyc;
    int            last_wr_cyc;
    logic [AW-1:0] wa_q[$];
    logic [DW-1:0] wd_q[$];

    reg_access_sequencer #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .SCAN_DIV (DIV)
    ) dut (
        .Clk       (clk),
        .Reset     (Reset),
        .Start     (Start),
        .Write_Req (Write_Req),
        .Scan_En   (Scan_En),
        .Select    (Select),
        .Addr      (Addr),
        .W_Addr    (W_Addr),
        .W_Data    (W_Data),
        .Write_Reg (Write_Reg),
        .R_Addr_A  (R_Addr_A),
        .R_Addr_B  (R_Addr_B),
        .Busy      (Busy),
        .Done      (Done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_pattern(input logic [1:0] sel, input int a);
        longint p2;
        p2 = 1;
        for (int i = 0; i < a; i++) p2 = p2 * 2;
        case (sel)
            2'd0:    return 32'(a);
            2'd1:    return 32'(longint'(a) * 64'h0101_0101);
            2'd2:    return 32'(p2);
            default: return ~32'(p2);
        endcase
    endfunction

    task automatic clear_mon();
        cyc          = 0;
        done_cnt     = 0;
        done_cyc     = -1;
        busy_cnt     = 0;
        first_wr_cyc = -1;
        last_wr_cyc  = -1;
        wa_q.delete();
        wd_q.delete();
    endtask

    // One clock, then sample outputs 1 ns after the edge and log activity.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (Write_Reg === 1'b1) begin
            if (wa_q.size() == 0) first_wr_cyc = cyc;
            last_wr_cyc = cyc;
            wa_q.push_back(W_Addr);
            wd_q.push_back(W_Data);
        end
        if (Done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (Busy === 1'b1) busy_cnt++;
    endtask

    task automatic test_reset();
        logic [AW-1:0] idle_addr;
        bit            found;
        // Power-on reset values
        n_checks++;
        if ({W_Addr, W_Data, Write_Reg, R_Addr_A, R_Addr_B, Busy, Done} !== '0)
            $display("FAIL reset_init: got W_Addr=%0d W_Data=%h WR=%b A=%0d B=%0d Busy=%b Done=%b expected all 0",
                     W_Addr, W_Data, Write_Reg, R_Addr_A, R_Addr_B, Busy, Done);
        else n_pass++;
        step();
        Reset = 1'b1;
        step();

        // Reset in the middle of a sweep
        Select = 2'($urandom_range(0, 3));
        clear_mon();
        Start = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            if (Write_Reg === 1'b1 && W_Addr === AW'(13)) found = 1'b1;
        end
        n_checks++;
        if (!found) $display("FAIL reset_reach_addr13: got no write to 13 expected one within 60 cycles");
        else n_pass++;

        Reset = 1'b0;
        Start = 1'b0;
        #1;
        n_checks++;
        if ({W_Addr, W_Data, Write_Reg, R_Addr_A, R_Addr_B, Busy, Done} !== '0)
            $display("FAIL reset_mid_init: got W_Addr=%0d W_Data=%h WR=%b Busy=%b expected all 0",
                     W_Addr, W_Data, Write_Reg, Busy);
        else n_pass++;
        step();
        step();

        idle_addr = AW'($urandom_range(0, 31));
        Addr      = idle_addr;
        Reset     = 1'b1;
        clear_mon();
        step();
        n_checks++;
        if (R_Addr_A !== idle_addr || R_Addr_B !== AW'((int'(idle_addr) + 1) % 32))
            $display("FAIL reset_idle_reload: got A=%0d B=%0d expected A=%0d B=%0d",
                     R_Addr_A, R_Addr_B, idle_addr, (int'(idle_addr) + 1) % 32);
        else n_pass++;
        for (int i = 0; i < 5; i++) step();
        n_checks++;
        if (wa_q.size() != 0 || busy_cnt != 0)
            $display("FAIL reset_then_idle: got %0d writes busy=%0d expected 0 writes busy=0",
                     wa_q.size(), busy_cnt);
        else n_pass++;
    endtask

    // mode 0: plain sweep, 1: Start and Write_Req rise together, 2: Write_Req rises mid-sweep
    task automatic test_init_sweep(input logic [1:0] sel, input int mode);
        int n;
        Addr   = AW'(7);
        Select = sel;
        clear_mon();
        Start = 1'b1;
        if (mode == 1) Write_Req = 1'b1;
        for (int i = 0; i < 45; i++) begin
            step();
            if (mode == 2 && cyc == 10) Write_Req = 1'b1;
        end
        Start     = 1'b0;
        Write_Req = 1'b0;
        step();
        step();

        n_checks++;
        if (wa_q.size() != 32)
            $display("FAIL init_m%0d_write_count: got %0d expected 32", mode, wa_q.size());
        else n_pass++;
        n = (wa_q.size() < 32) ? wa_q.size() : 32;
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (wa_q[i] !== AW'(i) || wd_q[i] !== ref_pattern(sel, i))
                $display("FAIL init_m%0d_write%0d: got addr=%0d data=%h expected addr=%0d data=%h",
                         mode, i, wa_q[i], wd_q[i], i, ref_pattern(sel, i));
            else n_pass++;
        end
        n_checks++;
        if (first_wr_cyc != 2)
            $display("FAIL init_m%0d_latency: got first write at cycle %0d expected 2", mode, first_wr_cyc);
        else n_pass++;
        n_checks++;
        if (done_cnt != 1 || done_cyc != last_wr_cyc + 1)
            $display("FAIL init_m%0d_done: got count=%0d at cycle %0d expected 1 at cycle %0d",
                     mode, done_cnt, done_cyc, last_wr_cyc + 1);
        else n_pass++;
        n_checks++;
        if (busy_cnt != 32)
            $display("FAIL init_m%0d_busy: got %0d busy cycles expected 32", mode, busy_cnt);
        else n_pass++;
    endtask

    task automatic test_manual_write(input logic [AW-1:0] a, input logic [1:0] sel);
        Addr   = a;
        Select = sel;
        clear_mon();
        Write_Req = 1'b1;
        for (int i = 0; i < 6; i++) step();
        Write_Req = 1'b0;
        step();
        n_checks++;
        if (wa_q.size() != 1 || wa_q[0] !== a || wd_q[0] !== ref_pattern(sel, int'(a)))
            $display("FAIL mwr_a%0d_s%0d: got %0d writes first addr=%0d data=%h expected 1 write addr=%0d data=%h",
                     a, sel, wa_q.size(), (wa_q.size() > 0) ? wa_q[0] : AW'(0),
                     (wd_q.size() > 0) ? wd_q[0] : DW'(0), a, ref_pattern(sel, int'(a)));
        else n_pass++;
        n_checks++;
        if (first_wr_cyc != 2 || busy_cnt != 1 || done_cnt != 0)
            $display("FAIL mwr_timing: got write cycle=%0d busy=%0d done=%0d expected 2/1/0",
                     first_wr_cyc, busy_cnt, done_cnt);
        else n_pass++;
    endtask

    task automatic test_scan(input int start_addr);
        int exp_a;
        int hold_a;
        Scan_En = 1'b0;
        Addr    = AW'(start_addr);
        step();
        step();
        clear_mon();
        Scan_En = 1'b1;
        exp_a   = start_addr;
        for (int k = 0; k < 24; k++) begin
            step();
            exp_a = (start_addr + k / int'(DIV)) % 32;
            n_checks++;
            if (R_Addr_A !== AW'(exp_a) || R_Addr_B !== AW'((exp_a + 1) % 32) || Write_Reg !== 1'b0)
                $display("FAIL scan_s%0d_k%0d: got A=%0d B=%0d WR=%b expected A=%0d B=%0d WR=0",
                         start_addr, k, R_Addr_A, R_Addr_B, Write_Reg, exp_a, (exp_a + 1) % 32);
            else n_pass++;
        end
        hold_a  = exp_a;
        Scan_En = 1'b0;
        Addr    = AW'((start_addr + 11) % 32);
        step();
        n_checks++;
        if (R_Addr_A !== AW'(hold_a) || R_Addr_B !== AW'((hold_a + 1) % 32))
            $display("FAIL scan_exit_hold: got A=%0d B=%0d expected A=%0d B=%0d",
                     R_Addr_A, R_Addr_B, hold_a, (hold_a + 1) % 32);
        else n_pass++;
        step();
        n_checks++;
        if (R_Addr_A !== AW'((start_addr + 11) % 32))
            $display("FAIL scan_exit_reload: got A=%0d expected %0d", R_Addr_A, (start_addr + 11) % 32);
        else n_pass++;
        n_checks++;
        if (busy_cnt != 0)
            $display("FAIL scan_busy: got %0d busy cycles expected 0", busy_cnt);
        else n_pass++;
    endtask

    task automatic test_scan_preempt();
        Addr   = AW'($urandom_range(0, 31));
        Select = 2'($urandom_range(0, 3));
        step();
        clear_mon();
        Scan_En = 1'b1;
        for (int i = 0; i < 7; i++) step();
        Write_Req = 1'b1;
        for (int i = 0; i < 6; i++) step();
        Write_Req = 1'b0;
        Scan_En   = 1'b0;
        step();
        step();
        n_checks++;
        if (wa_q.size() != 1 || wa_q[0] !== Addr || wd_q[0] !== ref_pattern(Select, int'(Addr)))
            $display("FAIL scan_preempt_mwr: got %0d writes expected 1 write to %0d data %h",
                     wa_q.size(), Addr, ref_pattern(Select, int'(Addr)));
        else n_pass++;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        Reset     = 1'b0;
        Start     = 1'b0;
        Write_Req = 1'b0;
        Scan_En   = 1'b0;
        Select    = 2'b00;
        Addr      = '0;
        clear_mon();
        #2;

        test_reset();
        test_init_sweep(2'b10, 0);
        test_init_sweep(2'($urandom_range(0, 3)), 0);
        test_init_sweep(2'($urandom_range(0, 3)), 1);
        test_init_sweep(2'($urandom_range(0, 3)), 2);
        test_manual_write(AW'(5), 2'b01);
        for (int i = 0; i < 6; i++)
            test_manual_write(AW'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
        test_scan(0);
        test_scan($urandom_range(26, 31));
        test_scan_preempt();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
